// File: rtl/alarm_unit.sv
// Daily alarm stage: stores an editable alarm time, matches it against live BCD time,
// and drives ringing with snooze (limited count) and auto-timeout.
module alarm_unit #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_MINUTES = 5,
   parameter int MAX_SNOOZES    = 3
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic [7:0] hr_bcd,
   input  logic [7:0] min_bcd,
   input  logic [7:0] sec_bcd,
   input  logic       arm_sw,
   input  logic       set_en,
   input  logic       pulse_sel,
   input  logic       pulse_incr,
   input  logic       pulse_decr,
   input  logic       pulse_ack,
   input  logic       pulse_snooze,
   output logic [7:0] alarm_hr_bcd,
   output logic [7:0] alarm_min_bcd,
   output logic       edit_field,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RING = 2'd2, SNOOZE = 2'd3} state_t;

   state_t      state_r;
   logic [7:0]  alarm_hr_r, alarm_min_r, snooze_hr_r, snooze_min_r, ring_timer_r;
   logic        edit_field_r, hit_q_r;
   logic [1:0]  snooze_cnt_r;

   logic [7:0]  alarm_hr_nx_s, alarm_min_nx_s, snz_hr_s, snz_min_s, min_sum_s, hr_sum_s;
   logic [7:0]  target_hr_s, target_min_s;
   logic        edit_field_nx_s, hit_s, trigger_s;

   function automatic logic [7:0] bcd2bin(input logic [7:0] b);
      return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
   endfunction

   function automatic logic [7:0] bin2bcd(input logic [7:0] v);
      return ((v / 8'd10) << 3'd4) | (v % 8'd10);
   endfunction

   function automatic logic [7:0] wrap_inc(input logic [7:0] b, input logic [7:0] top);
      if (bcd2bin(b) >= top) return 8'h00;
      else                   return bin2bcd(bcd2bin(b) + 8'd1);
   endfunction

   function automatic logic [7:0] wrap_dec(input logic [7:0] b, input logic [7:0] top);
      if (bcd2bin(b) == 8'd0) return bin2bcd(top);
      else                    return bin2bcd(bcd2bin(b) - 8'd1);
   endfunction

   // Match against the alarm time, or the snooze time while snoozing; only the rising edge triggers
   always_comb begin
      target_hr_s  = alarm_hr_r;
      target_min_s = alarm_min_r;
      if (state_r == SNOOZE) begin
         target_hr_s  = snooze_hr_r;
         target_min_s = snooze_min_r;
      end else begin
         target_hr_s  = alarm_hr_r;
         target_min_s = alarm_min_r;
      end
      hit_s     = (hr_bcd == target_hr_s) && (min_bcd == target_min_s) && (sec_bcd == 8'h00);
      trigger_s = hit_s && !hit_q_r && !set_en;
   end

   // Snooze target: live HH:MM plus SNOOZE_MINUTES with minute->hour carry and day wrap
   always_comb begin
      min_sum_s = bcd2bin(min_bcd) + 8'(SNOOZE_MINUTES);
      if (min_sum_s >= 8'd60) begin
         snz_min_s = bin2bcd(min_sum_s - 8'd60);
         hr_sum_s  = bcd2bin(hr_bcd) + 8'd1;
      end else begin
         snz_min_s = bin2bcd(min_sum_s);
         hr_sum_s  = bcd2bin(hr_bcd);
      end
      if (hr_sum_s >= 8'd24) snz_hr_s = 8'h00;
      else                   snz_hr_s = bin2bcd(hr_sum_s);
   end

   // Alarm-time editing; each field wraps on its own, incr and decr together cancel
   always_comb begin
      alarm_hr_nx_s   = alarm_hr_r;
      alarm_min_nx_s  = alarm_min_r;
      edit_field_nx_s = edit_field_r;
      if (set_en) begin
         if (pulse_sel) edit_field_nx_s = ~edit_field_r;
         else           edit_field_nx_s = edit_field_r;
         if (pulse_incr && !pulse_decr) begin
            if (!edit_field_r) alarm_hr_nx_s  = wrap_inc(alarm_hr_r, 8'd23);
            else               alarm_min_nx_s = wrap_inc(alarm_min_r, 8'd59);
         end else if (pulse_decr && !pulse_incr) begin
            if (!edit_field_r) alarm_hr_nx_s  = wrap_dec(alarm_hr_r, 8'd23);
            else               alarm_min_nx_s = wrap_dec(alarm_min_r, 8'd59);
         end else begin
            alarm_hr_nx_s  = alarm_hr_r;
            alarm_min_nx_s = alarm_min_r;
         end
      end else begin
         edit_field_nx_s = edit_field_r;
      end
   end

   // Alarm FSM, edit registers, ring timer and snooze bookkeeping
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         alarm_hr_r   <= 8'h06;
         alarm_min_r  <= 8'h00;
         edit_field_r <= 1'b0;
         snooze_hr_r  <= 8'h00;
         snooze_min_r <= 8'h00;
         ring_timer_r <= 8'd0;
         snooze_cnt_r <= 2'd0;
         hit_q_r      <= 1'b0;
      end else begin
         hit_q_r      <= hit_s;
         alarm_hr_r   <= alarm_hr_nx_s;
         alarm_min_r  <= alarm_min_nx_s;
         edit_field_r <= edit_field_nx_s;
         if (!arm_sw) begin
            state_r      <= IDLE;
            snooze_cnt_r <= 2'd0;
         end else if (set_en) begin
            state_r      <= ARMED;
            snooze_cnt_r <= 2'd0;
         end else begin
            case (state_r)
               IDLE: state_r <= ARMED;
               ARMED: begin
                  if (trigger_s) begin
                     state_r      <= RING;
                     ring_timer_r <= 8'd0;
                  end
               end
               RING: begin
                  // Ack and snooze outrank a timeout landing in the same cycle
                  if (pulse_ack) begin
                     state_r      <= ARMED;
                     snooze_cnt_r <= 2'd0;
                  end else if (pulse_snooze) begin
                     if (snooze_cnt_r < 2'(MAX_SNOOZES)) begin
                        state_r      <= SNOOZE;
                        snooze_cnt_r <= snooze_cnt_r + 2'd1;
                        snooze_hr_r  <= snz_hr_s;
                        snooze_min_r <= snz_min_s;
                     end else begin
                        state_r      <= ARMED;
                        snooze_cnt_r <= 2'd0;
                     end
                  end else if (tick_1hz) begin
                     if (ring_timer_r >= 8'(RING_SECONDS - 1)) begin
                        state_r      <= ARMED;
                        snooze_cnt_r <= 2'd0;
                     end else begin
                        ring_timer_r <= ring_timer_r + 8'd1;
                     end
                  end
               end
               SNOOZE: begin
                  if (pulse_ack) begin
                     state_r      <= ARMED;
                     snooze_cnt_r <= 2'd0;
                  end else if (trigger_s) begin
                     state_r      <= RING;
                     ring_timer_r <= 8'd0;
                  end
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign alarm_hr_bcd  = alarm_hr_r;
   assign alarm_min_bcd = alarm_min_r;
   assign edit_field    = edit_field_r;
   assign ringing       = (state_r == RING);
   assign snoozing      = (state_r == SNOOZE);
   assign snooze_cnt    = snooze_cnt_r;

endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit: directed stimulus queues expected outputs, a monitor compares.
module tb_alarm_unit;
   logic       CLOCK_50 = 1'b0;
   logic       rst_n, tick_1hz, arm_sw, set_en;
   logic       pulse_sel, pulse_incr, pulse_decr, pulse_ack, pulse_snooze;
   logic [7:0] hr_bcd, min_bcd, sec_bcd, alarm_hr_bcd, alarm_min_bcd;
   logic       edit_field, ringing, snoozing;
   logic [1:0] snooze_cnt;

   typedef struct packed {
      logic [95:0] tag;
      logic        ring;
      logic        snz;
      logic [1:0]  cnt;
      logic [7:0]  ahr;
      logic [7:0]  amin;
      logic        ef;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad   = 0;
   logic [7:0] e_ahr, e_amin;
   logic       e_ef;

   alarm_unit dut (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n), .tick_1hz(tick_1hz),
      .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
      .arm_sw(arm_sw), .set_en(set_en), .pulse_sel(pulse_sel),
      .pulse_incr(pulse_incr), .pulse_decr(pulse_decr), .pulse_ack(pulse_ack),
      .pulse_snooze(pulse_snooze), .alarm_hr_bcd(alarm_hr_bcd), .alarm_min_bcd(alarm_min_bcd),
      .edit_field(edit_field), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic set_t(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      hr_bcd  = h;
      min_bcd = m;
      sec_bcd = s;
   endtask

   // 0 sel, 1 incr, 2 decr, 3 ack, 4 snooze, 5 tick, 6 incr+decr
   task automatic pulse(input int k);
      pulse_sel    = (k == 0);
      pulse_incr   = (k == 1) || (k == 6);
      pulse_decr   = (k == 2) || (k == 6);
      pulse_ack    = (k == 3);
      pulse_snooze = (k == 4);
      tick_1hz     = (k == 5);
      cyc();
      {pulse_sel, pulse_incr, pulse_decr, pulse_ack, pulse_snooze, tick_1hz} = 6'b0;
   endtask

   task automatic expect_now(input logic [95:0] tag, input logic ring, input logic snz,
                             input logic [1:0] cnt);
      sb_q.push_back('{tag, ring, snz, cnt, e_ahr, e_amin, e_ef});
   endtask

   // Monitor: output sampled on the falling edge against the oldest queued expectation
   initial begin
      forever begin
         @(negedge CLOCK_50);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            total++;
            if ({ringing, snoozing, snooze_cnt, alarm_hr_bcd, alarm_min_bcd, edit_field} !==
                {mon_e.ring, mon_e.snz, mon_e.cnt, mon_e.ahr, mon_e.amin, mon_e.ef}) begin
               bad++;
               $display("FAIL %s: got ring=%b snz=%b cnt=%0d alarm=%h:%h ef=%b, want ring=%b snz=%b cnt=%0d alarm=%h:%h ef=%b",
                        mon_e.tag, ringing, snoozing, snooze_cnt, alarm_hr_bcd, alarm_min_bcd, edit_field,
                        mon_e.ring, mon_e.snz, mon_e.cnt, mon_e.ahr, mon_e.amin, mon_e.ef);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; arm_sw = 1'b0; set_en = 1'b0;
      {pulse_sel, pulse_incr, pulse_decr, pulse_ack, pulse_snooze, tick_1hz} = 6'b0;
      set_t(8'h00, 8'h00, 8'h00);
      e_ahr = 8'h06; e_amin = 8'h00; e_ef = 1'b0;
      repeat (3) cyc();
      expect_now("reset", 1'b0, 1'b0, 2'd0);
      cyc();

      // First alarm event and auto-timeout after 60 ticks
      rst_n = 1'b1; arm_sw = 1'b1;
      set_t(8'h05, 8'h59, 8'h59);
      cyc(); cyc();
      expect_now("pre_match", 1'b0, 1'b0, 2'd0);
      set_t(8'h06, 8'h00, 8'h00);
      cyc();
      expect_now("ring_0600", 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 59; i++) begin
         pulse(5);
         cyc();
      end
      expect_now("tick59", 1'b1, 1'b0, 2'd0);
      pulse(5);
      expect_now("timeout", 1'b0, 1'b0, 2'd0);
      cyc(); cyc();
      expect_now("no_retrig", 1'b0, 1'b0, 2'd0);

      // Next day re-triggers exactly once
      set_t(8'h05, 8'h59, 8'h59);
      cyc();
      set_t(8'h06, 8'h00, 8'h00);
      cyc();
      expect_now("retrigger", 1'b1, 1'b0, 2'd0);
      pulse(3);
      expect_now("ack", 1'b0, 1'b0, 2'd0);
      repeat (3) cyc();
      expect_now("once", 1'b0, 1'b0, 2'd0);

      // Edit alarm to 23:58 through the wrap points
      set_en = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) pulse(2);
      e_ahr = 8'h00;
      expect_now("hr_to_00", 1'b0, 1'b0, 2'd0);
      pulse(2);
      e_ahr = 8'h23;
      expect_now("hr_wrap", 1'b0, 1'b0, 2'd0);
      pulse(0);
      e_ef = 1'b1;
      expect_now("sel_min", 1'b0, 1'b0, 2'd0);
      pulse(2);
      e_amin = 8'h59;
      expect_now("min_dwrap", 1'b0, 1'b0, 2'd0);
      pulse(1);
      e_amin = 8'h00;
      expect_now("min_wrap", 1'b0, 1'b0, 2'd0);
      pulse(6);
      expect_now("incr_decr", 1'b0, 1'b0, 2'd0);
      pulse(2); pulse(2);
      e_amin = 8'h58;
      expect_now("min_58", 1'b0, 1'b0, 2'd0);
      set_en = 1'b0;
      pulse(1);
      expect_now("edit_off", 1'b0, 1'b0, 2'd0);

      // Ring at 23:58, snooze across midnight, three snoozes then a fourth acts as ack
      set_t(8'h23, 8'h57, 8'h59);
      cyc();
      set_t(8'h23, 8'h58, 8'h00);
      cyc();
      expect_now("ring_2358", 1'b1, 1'b0, 2'd0);
      pulse(4);
      expect_now("snooze1", 1'b0, 1'b1, 2'd1);
      set_t(8'h00, 8'h02, 8'h59);
      cyc();
      expect_now("snz_wait", 1'b0, 1'b1, 2'd1);
      set_t(8'h00, 8'h03, 8'h00);
      cyc();
      expect_now("ring_0003", 1'b1, 1'b0, 2'd1);
      pulse(4);
      expect_now("snooze2", 1'b0, 1'b1, 2'd2);
      set_t(8'h00, 8'h07, 8'h59);
      cyc();
      set_t(8'h00, 8'h08, 8'h00);
      cyc();
      expect_now("ring_0008", 1'b1, 1'b0, 2'd2);
      pulse(4);
      expect_now("snooze3", 1'b0, 1'b1, 2'd3);
      set_t(8'h00, 8'h12, 8'h59);
      cyc();
      set_t(8'h00, 8'h13, 8'h00);
      cyc();
      expect_now("ring_0013", 1'b1, 1'b0, 2'd3);
      pulse(4);
      expect_now("snooze4_ack", 1'b0, 1'b0, 2'd0);

      // Disarm while ringing
      set_t(8'h23, 8'h57, 8'h59);
      cyc();
      set_t(8'h23, 8'h58, 8'h00);
      cyc();
      expect_now("ring_again", 1'b1, 1'b0, 2'd0);
      arm_sw = 1'b0;
      cyc();
      expect_now("disarm", 1'b0, 1'b0, 2'd0);

      // Async reset in the middle of a snooze
      arm_sw = 1'b1;
      set_t(8'h23, 8'h57, 8'h59);
      cyc();
      set_t(8'h23, 8'h58, 8'h00);
      cyc();
      expect_now("ring_rearm", 1'b1, 1'b0, 2'd0);
      pulse(4);
      expect_now("snz_pre_rst", 1'b0, 1'b1, 2'd1);
      @(posedge CLOCK_50);
      #5 rst_n = 1'b0;
      #1;
      e_ahr = 8'h06; e_amin = 8'h00; e_ef = 1'b0;
      expect_now("async_rst", 1'b0, 1'b0, 2'd0);
      cyc(); cyc();
      rst_n = 1'b1;

      for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge CLOCK_50);
      if (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
